// File: rtl/sig_pkg.sv
// Shared types and constants for the signal-conditioning blocks.
package sig_pkg;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_WAIT   = 1'b1
  } sig_state_e;

  localparam int             GLITCH_W   = 8;
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = 8'hFF;

endpackage

// File: rtl/sig_sync.sv
// Plain flop-chain synchronizer for a single asynchronous level.
module sig_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_r;

  // shift register, oldest sample at the top bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_r <= {STAGES{RST_VAL}};
    end else begin
      chain_r <= {chain_r[STAGES-2:0], d};
    end
  end

  assign q = chain_r[STAGES-1];

endmodule

// File: rtl/sig_debounce.sv
// Synchronizes a bouncy asynchronous level and commits a change only after
// DEBOUNCE_CYCLES consecutive differing samples; rejected candidates are counted.
module sig_debounce
  import sig_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 1000,
  parameter int   CNT_WIDTH       = 16,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sig_async,
  input  logic                glitch_clr,
  output logic                sig_stable,
  output logic                sig_busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 ||
      DEBOUNCE_CYCLES > ((1 << CNT_WIDTH) - 1)) begin : g_param_check
    $error("sig_debounce: illegal SYNC_STAGES or DEBOUNCE_CYCLES");
  end

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic                 SINGLE   = (DEBOUNCE_CYCLES == 1);

  sig_state_e           state_r, state_s;
  logic [CNT_WIDTH-1:0] cnt_r, cnt_s;
  logic                 stable_r, stable_s;
  logic                 reject_s;
  logic                 sync_q_s;
  logic [GLITCH_W-1:0]  glitch_r;

  sig_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (RESET_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sig_async),
    .q   (sync_q_s)
  );

  // next-state, counter and commit decision
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    stable_s = stable_r;
    reject_s = 1'b0;
    case (state_r)
      ST_STABLE: begin
        if (sync_q_s != stable_r) begin
          if (SINGLE) begin
            stable_s = sync_q_s;
          end else begin
            state_s = ST_WAIT;
            cnt_s   = CNT_WIDTH'(1);
          end
        end else begin
          state_s = ST_STABLE;
        end
      end
      ST_WAIT: begin
        if (sync_q_s == stable_r) begin
          state_s  = ST_STABLE;
          cnt_s    = '0;
          reject_s = 1'b1;
        end else if (cnt_r == CNT_LAST) begin
          stable_s = sync_q_s;
          state_s  = ST_STABLE;
          cnt_s    = '0;
        end else begin
          cnt_s = cnt_r + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_s = ST_STABLE;
        cnt_s   = '0;
      end
    endcase
  end

  // state, counter and debounced level registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_STABLE;
      cnt_r    <= '0;
      stable_r <= RESET_LEVEL;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      stable_r <= stable_s;
    end
  end

  // saturating reject counter; a clear beats a same-cycle reject
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glitch_r <= '0;
    end else if (glitch_clr) begin
      glitch_r <= '0;
    end else if (reject_s && (glitch_r != GLITCH_MAX)) begin
      glitch_r <= glitch_r + 8'd1;
    end else begin
      glitch_r <= glitch_r;
    end
  end

  assign sig_stable = stable_r;
  assign sig_busy   = (state_r == ST_WAIT);
  assign glitch_cnt = glitch_r;

endmodule

// File: tb/tb_sig_debounce.sv
// Directed, table-driven bench for sig_debounce (DEBOUNCE_CYCLES=4 and =1 builds).
module tb_sig_debounce;

  typedef struct {
    logic       a;
    logic       clr;
    logic       exp_stable;
    logic       exp_busy;
    logic [7:0] exp_glitch;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a = 1'b0;
  logic       a1 = 1'b0;
  logic       clr = 1'b0;
  logic       stable, busy, stable1, busy1;
  logic [7:0] gl, gl1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sig_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(16), .RESET_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .sig_async(a), .glitch_clr(clr),
    .sig_stable(stable), .sig_busy(busy), .glitch_cnt(gl)
  );

  sig_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .CNT_WIDTH(16), .RESET_LEVEL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .sig_async(a1), .glitch_clr(clr),
    .sig_stable(stable1), .sig_busy(busy1), .glitch_cnt(gl1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    a   = v.a;
    clr = v.clr;
    tick();
    chk({name, "_stable"}, int'(stable), int'(v.exp_stable));
    chk({name, "_busy"},   int'(busy),   int'(v.exp_busy));
    chk({name, "_glitch"}, int'(gl),     int'(v.exp_glitch));
  endtask

  task automatic glitch_once();
    a = 1'b1; tick();
    a = 1'b0; tick(); tick(); tick();
  endtask

  vec_t t1[7];
  vec_t t3[12];
  int   n;

  initial begin
    // reset release with input already high
    t1[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    t1[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    t1[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
    t1[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
    t1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
    t1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
    t1[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
    // one-cycle pulse, then three-cycle pulse
    t3[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    t3[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    t3[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    t3[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    t3[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    t3[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
    t3[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
    t3[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
    t3[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    t3[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    t3[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
    t3[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd2};

    // Test 1
    a = 1'b1;
    tick(); tick(); tick();
    chk("t1_rst_stable", int'(stable), 0);
    chk("t1_rst_busy",   int'(busy),   0);
    chk("t1_rst_glitch", int'(gl),     0);
    chk("t1_rst_stable1", int'(stable1), 0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) run_vec($sformatf("t1_e%0d", i + 1), t1[i]);

    // Test 2: clean steps, latency measured in edges
    a = 1'b0; n = 0;
    do begin tick(); n++; end while (stable !== 1'b0 && n < 50);
    chk("t2_fall0_lat", n, 6);
    repeat (20 - n) tick();
    a = 1'b1; n = 0;
    do begin tick(); n++; end while (stable !== 1'b1 && n < 50);
    chk("t2_rise_lat", n, 6);
    repeat (20 - n) tick();
    a = 1'b0; n = 0;
    do begin tick(); n++; end while (stable !== 1'b0 && n < 50);
    chk("t2_fall_lat", n, 6);
    repeat (20 - n) tick();
    chk("t2_glitch", int'(gl), 0);

    // Test 3
    for (int i = 0; i < 12; i++) run_vec($sformatf("t3_r%0d", i), t3[i]);

    // Test 4: saturation, then clear coincident with a reject
    for (int i = 0; i < 300; i++) glitch_once();
    chk("t4_sat", int'(gl), 255);
    chk("t4_sat_stable", int'(stable), 0);
    run_vec("t4_c1a", '{1'b1, 1'b0, 1'b0, 1'b0, 8'd255});
    run_vec("t4_c1b", '{1'b0, 1'b0, 1'b0, 1'b0, 8'd255});
    run_vec("t4_c1c", '{1'b0, 1'b0, 1'b0, 1'b1, 8'd255});
    run_vec("t4_c1d", '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
    run_vec("t4_c2a", '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
    run_vec("t4_c2b", '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
    run_vec("t4_c2c", '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0});
    run_vec("t4_c2d", '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
    clr = 1'b0;
    glitch_once();
    chk("t4_resume", int'(gl), 1);

    // Test 5: reset mid-qualification
    run_vec("t5_e1", '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1});
    run_vec("t5_e2", '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1});
    run_vec("t5_e3", '{1'b1, 1'b0, 1'b0, 1'b1, 8'd1});
    run_vec("t5_e4", '{1'b1, 1'b0, 1'b0, 1'b1, 8'd1});
    a   = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rst_busy",   int'(busy),   0);
    chk("t5_rst_stable", int'(stable), 0);
    chk("t5_rst_glitch", int'(gl),     0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("t5_post%0d_stable", i), int'(stable), 0);
      chk($sformatf("t5_post%0d_busy", i),   int'(busy),   0);
    end

    // Test 6: single-cycle qualification build
    a1 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("t6_rise_e%0d", i), int'(stable1), (i >= 3) ? 1 : 0);
      chk($sformatf("t6_rise_busy%0d", i), int'(busy1), 0);
    end
    a1 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("t6_fall_e%0d", i), int'(stable1), (i >= 3) ? 0 : 1);
      chk($sformatf("t6_fall_busy%0d", i), int'(busy1), 0);
    end
    chk("t6_glitch", int'(gl1), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
